// File: rtl/mac_accum_param_1_pkg.sv
// Shared defaults for the MAC stage and the downstream ReLU/truncation stage.
// Both blocks import these values so their data, accumulator and phase-counter
// widths agree.
package mac_accum_param_1_pkg;

  // Q4.12 pixel and weight samples.
  localparam int unsigned MAC_DATA_WIDTH           = 16;
  // Signed accumulator and result width.
  localparam int unsigned MAC_ACCUM_DATA_WIDTH     = 32;
  // Width of the count_sload phase counter. It must be able to hold KERNEL_LEN-1.
  localparam int unsigned MAC_COUNT_SLOAD_BITWIDTH = 5;
  // Number of products in one window (5x5 kernel).
  localparam int unsigned MAC_KERNEL_LEN           = 25;

endpackage : mac_accum_param_1_pkg

// File: rtl/mac_accum_param_1_mult.sv
// mult_param_1: registered signed DATA_WIDTH x DATA_WIDTH multiplier.
// It is the stage-1 product register of the MAC and maps onto a hard DSP.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-high; clears the product
//   enable - load a new product; low holds the product
//   a, b   - signed operands
//   prod   - registered full-precision signed product (2*DATA_WIDTH bits)
module mult_param_1
  import mac_accum_param_1_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MAC_DATA_WIDTH
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic signed [DATA_WIDTH-1:0]   a,
  input  logic signed [DATA_WIDTH-1:0]   b,
  output logic signed [2*DATA_WIDTH-1:0] prod
);

  localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

  // Operands are sign-extended to the full product width, so the product never truncates.
  always_ff @(posedge clock) begin
    if (reset) begin
      prod <= '0;
    end else if (enable) begin
      prod <= PROD_WIDTH'(a) * PROD_WIDTH'(b);
    end
  end

endmodule : mult_param_1

// File: rtl/mac_accum_param_1.sv
// mac_accum_param_1: streaming signed multiply-accumulate stage.
// It accepts one pixel/weight pair per enabled cycle, sums KERNEL_LEN products
// into one window, and holds that window's sum on result until the next window
// completes.
// Ports:
//   clock        - rising-edge clock
//   reset        - synchronous, active-high; has priority over enable
//   enable       - advance the pipeline; low stalls and holds all state
//   data_in      - signed pixel sample
//   weight_in    - signed weight sample
//   result       - signed sum of the last completed window
//   count_sload  - index of the sample accepted this cycle
//   result_valid - one-clock pulse when result updates
module mac_accum_param_1
  import mac_accum_param_1_pkg::*;
#(
  parameter int unsigned DATA_WIDTH           = MAC_DATA_WIDTH,
  parameter int unsigned ACCUM_DATA_WIDTH     = MAC_ACCUM_DATA_WIDTH,
  parameter int unsigned COUNT_SLOAD_BITWIDTH = MAC_COUNT_SLOAD_BITWIDTH,
  parameter int unsigned KERNEL_LEN           = MAC_KERNEL_LEN
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               enable,
  input  logic signed [DATA_WIDTH-1:0]       data_in,
  input  logic signed [DATA_WIDTH-1:0]       weight_in,
  output logic signed [ACCUM_DATA_WIDTH-1:0] result,
  output logic [COUNT_SLOAD_BITWIDTH-1:0]    count_sload,
  output logic                               result_valid
);

  localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;
  localparam logic [COUNT_SLOAD_BITWIDTH-1:0] LAST_IDX =
    COUNT_SLOAD_BITWIDTH'(KERNEL_LEN - 1);

  logic signed [PROD_WIDTH-1:0]       prod_r;
  logic                               first_r;
  logic                               last_r;
  logic                               vld_r;
  logic signed [ACCUM_DATA_WIDTH-1:0] acc;
  logic signed [ACCUM_DATA_WIDTH-1:0] sum_c;

  // Stage 1 product register.
  mult_param_1 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mult (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .a      (data_in),
    .b      (weight_in),
    .prod   (prod_r)
  );

  // The first product of a window reloads the accumulator. Because of this,
  // back-to-back windows lose no cycle between them.
  always_comb begin
    sum_c = acc + ACCUM_DATA_WIDTH'(prod_r);
    if (first_r) begin
      sum_c = ACCUM_DATA_WIDTH'(prod_r);
    end
  end

  // Phase counter, stage-1 flags, and stage-2 accumulate/retire.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_sload  <= '0;
      first_r      <= 1'b0;
      last_r       <= 1'b0;
      vld_r        <= 1'b0;
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (enable) begin
        count_sload <= (count_sload == LAST_IDX) ? '0
                                                 : count_sload + COUNT_SLOAD_BITWIDTH'(1);
        first_r     <= (count_sload == '0);
        last_r      <= (count_sload == LAST_IDX);
        vld_r       <= 1'b1;
        if (vld_r) begin
          acc <= sum_c;
          if (last_r) begin
            result       <= sum_c;
            result_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule : mac_accum_param_1
